// File: rtl/cond_logic_pkg.sv
// Shared controller definitions: condition-code encodings and NZCV bit positions.
package cond_logic_pkg;

    // ARM condition field encodings (Instr[31:28])
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // Bit positions of the status flags inside a {N,Z,C,V} nibble
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/FSM-to-datapath signal bundle around the conditional-execution stage.
interface cond_logic_if;
    import cond_logic_pkg::*;

    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

    // Controller side: issues requests, receives gated strobes
    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        input  PCWrite, RegWrite, MemWrite, Flags
    );

    // Conditional-execution stage side
    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        output PCWrite, RegWrite, MemWrite, Flags
    );

endinterface

// File: rtl/cond_logic_cond_check.sv
// Combinational condition evaluator: (Cond, Flags) -> CondEx.
module cond_logic_cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    logic ge;

    assign n  = flags[N_IDX];
    assign z  = flags[Z_IDX];
    assign c  = flags[C_IDX];
    assign v  = flags[V_IDX];
    assign ge = (n == v);

    // Decode the condition field against the current flags; NV and unknown encodings never execute
    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z & ge;
            COND_LE: cond_ex = z | ~ge;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates Cond, gates PC/register/memory writes.
module cond_logic
    import cond_logic_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    cond_logic_if.slave   bus
);

    logic [1:0] flags_nz_q, flags_nz_d;
    logic [1:0] flags_cv_q, flags_cv_d;
    logic       cond_ex_delayed_q, cond_ex_delayed_d;
    logic [3:0] flags_cur;
    logic       cond_ex;
    logic [1:0] flag_write;

    assign flags_cur = {flags_nz_q, flags_cv_q};

    cond_logic_cond_check u_cond_check (
        .cond    (bus.Cond),
        .flags   (flags_cur),
        .cond_ex (cond_ex)
    );

    // Next-state: each flag half reloads only when its enable is set and the condition passes;
    // the decision always comes from the pre-update flags
    always_comb begin
        flag_write        = bus.FlagW & {2{cond_ex}};
        flags_nz_d        = flags_nz_q;
        flags_cv_d        = flags_cv_q;
        cond_ex_delayed_d = cond_ex;
        if (flag_write[1]) begin
            flags_nz_d = bus.ALUFlags[N_IDX:Z_IDX];
        end
        if (flag_write[0]) begin
            flags_cv_d = bus.ALUFlags[C_IDX:V_IDX];
        end
    end

    // State registers; reset overrides any flag write on the same edge and drops a pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_nz_q        <= 2'b00;
            flags_cv_q        <= 2'b00;
            cond_ex_delayed_q <= 1'b0;
        end else begin
            flags_nz_q        <= flags_nz_d;
            flags_cv_q        <= flags_cv_d;
            cond_ex_delayed_q <= cond_ex_delayed_d;
        end
    end

    // Output strobes use the Decode-time decision; the fetch increment is never suppressed
    always_comb begin
        bus.PCWrite  = (bus.PCS & cond_ex_delayed_q) | bus.NextPC;
        bus.RegWrite = bus.RegW & cond_ex_delayed_q;
        bus.MemWrite = bus.MemW & cond_ex_delayed_q;
        bus.Flags    = flags_cur;
    end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios, full condition sweep, random traffic.
module tb_cond_logic;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    // Reference state
    logic [3:0] m_flags;
    logic       m_cxd;

    cond_logic_if bus ();

    cond_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM-style evaluation: the upper three bits select a base test, bit 0 inverts it
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        logic base [8];
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        base[0] = z;
        base[1] = cf;
        base[2] = n;
        base[3] = v;
        base[4] = cf & ~z;
        base[5] = (n == v);
        base[6] = ~z & (n == v);
        base[7] = 1'b1;
        return base[c[3:1]] ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check outputs against the model for the current inputs, then advance one clock
    task automatic step(input bit do_check);
        logic       cx;
        logic [3:0] nf;
        logic       ncxd;
        #1;
        if (do_check) begin
            chk("flags", bus.Flags, m_flags);
            chk("regwrite", {3'b0, bus.RegWrite}, {3'b0, bus.RegW & m_cxd});
            chk("memwrite", {3'b0, bus.MemWrite}, {3'b0, bus.MemW & m_cxd});
            chk("pcwrite", {3'b0, bus.PCWrite}, {3'b0, (bus.PCS & m_cxd) | bus.NextPC});
        end
        cx   = model_cond(bus.Cond, m_flags);
        nf   = m_flags;
        ncxd = cx;
        if (cx && bus.FlagW[1]) nf[3:2] = bus.ALUFlags[3:2];
        if (cx && bus.FlagW[0]) nf[1:0] = bus.ALUFlags[1:0];
        if (reset) begin
            nf   = 4'b0000;
            ncxd = 1'b0;
        end
        @(posedge clk);
        #1;
        m_flags = nf;
        m_cxd   = ncxd;
    endtask

    task automatic set_in(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                          input logic pcs, input logic npc, input logic rw, input logic mw);
        bus.Cond     = c;
        bus.ALUFlags = alu;
        bus.FlagW    = fw;
        bus.PCS      = pcs;
        bus.NextPC   = npc;
        bus.RegW     = rw;
        bus.MemW     = mw;
    endtask

    // Load the flags with an unconditional full flag write
    task automatic load_flags(input logic [3:0] f);
        set_in(4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        m_flags = 4'b0000;
        m_cxd   = 1'b0;

        // Reset held while writes are requested
        reset = 1'b1;
        set_in(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        step(0);
        step(1);
        chk("reset_flags", bus.Flags, 4'b0000);
        chk("reset_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
        chk("reset_memwrite", {3'b0, bus.MemWrite}, 4'b0000);
        chk("reset_pcwrite", {3'b0, bus.PCWrite}, 4'b0001);
        reset = 1'b0;

        // Split flag writes
        set_in(4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("split_nz", bus.Flags, 4'b1100);
        set_in(4'b1110, 4'b0011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("split_cv", bus.Flags, 4'b1111);

        // Condition sweep over every flag value and condition code
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                load_flags(4'(f));
                set_in(4'(c), 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
                step(1);
                chk($sformatf("sweep_f%0d_c%0d", f, c), {3'b0, bus.RegWrite},
                    {3'b0, model_cond(4'(c), 4'(f))});
            end
        end
        chk("sweep_nv", {3'b0, model_cond(4'b1111, bus.Flags)}, {3'b0, bus.RegWrite});

        // Suppressed write: EQ with Z clear
        load_flags(4'b0000);
        set_in(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1);
        chk("supp_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
        chk("supp_memwrite", {3'b0, bus.MemWrite}, 4'b0000);
        chk("supp_pcwrite", {3'b0, bus.PCWrite}, 4'b0000);
        bus.NextPC = 1'b1;
        #1;
        chk("supp_nextpc", {3'b0, bus.PCWrite}, 4'b0001);

        // Taken conditional branch: EQ with Z set
        load_flags(4'b0100);
        set_in(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("branch_taken", {3'b0, bus.PCWrite}, 4'b0001);

        // Conditional flag update
        load_flags(4'b0100);
        set_in(4'b0001, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("cond_flag_ne", bus.Flags, 4'b0100);
        set_in(4'b0000, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        chk("cond_flag_eq", bus.Flags, 4'b0010);

        // Reset mid-instruction drops the pending write
        load_flags(4'b0100);
        set_in(4'b0000, 4'b1010, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("midrst_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
        chk("midrst_flags", bus.Flags, 4'b0000);

        // Random traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            step(1);
        end
        reset = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
